// File: rtl/segasys1_vid_pkg.sv
// -----------------------------------------------------------------------------
// segasys1_vid_pkg
// Shared definitions for the character-ROM fetch scheduler:
//   - scheduler state encoding (ST_IDLE / ST_BUSY / ST_RESP)
//   - grant encoding (G_BG0 / G_BG1 / G_SPR)
//   - memory space select constants (MEM_SEL_TILE / MEM_SEL_SPR)
//   - address / data widths
//   - helpers: tile address widening, grant to strobe one-hot
// -----------------------------------------------------------------------------
package segasys1_vid_pkg;

    localparam int TILE_AW = 14;
    localparam int SPR_AW  = 18;
    localparam int MEM_DW  = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        G_BG0 = 2'd0,
        G_BG1 = 2'd1,
        G_SPR = 2'd2
    } grant_t;

    localparam logic MEM_SEL_TILE = 1'b0;
    localparam logic MEM_SEL_SPR  = 1'b1;

    // Tile addresses live at the bottom of the 18-bit memory space.
    function automatic logic [SPR_AW-1:0] tile_to_mem(input logic [TILE_AW-1:0] ad);
        return {{(SPR_AW-TILE_AW){1'b0}}, ad};
    endfunction

    // Strobe vector ordering is {spr, bg1, bg0}.
    function automatic logic [2:0] grant_onehot(input grant_t g);
        logic [2:0] oh;
        case (g)
            G_BG0:   oh = 3'b001;
            G_BG1:   oh = 3'b010;
            G_SPR:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/segasys1_vrom_prio.sv
// -----------------------------------------------------------------------------
// segasys1_vrom_prio
// Combinational fixed-priority encoder BG0 > BG1 > SPR, with a promote input
// that lets a pending sprite request jump ahead of both backgrounds.
// Ports:
//   bg0_req, bg1_req, spr_req  in   request levels
//   promote                    in   sprite promotion (starvation relief)
//   any_req                    out  at least one request pending
//   grant                      out  winning requester (valid when any_req)
// -----------------------------------------------------------------------------
import segasys1_vid_pkg::*;

module segasys1_vrom_prio (
    input  logic   bg0_req,
    input  logic   bg1_req,
    input  logic   spr_req,
    input  logic   promote,
    output logic   any_req,
    output grant_t grant
);

    // Priority select; the promoted sprite overrides the fixed order.
    always_comb begin
        any_req = bg0_req | bg1_req | spr_req;
        grant   = G_BG0;
        if (promote && spr_req) begin
            grant = G_SPR;
        end else if (bg0_req) begin
            grant = G_BG0;
        end else if (bg1_req) begin
            grant = G_BG1;
        end else if (spr_req) begin
            grant = G_SPR;
        end else begin
            grant = G_BG0;
        end
    end

endmodule

// File: rtl/segasys1_vrom_sched.sv
// -----------------------------------------------------------------------------
// segasys1_vrom_sched
// Shares one character-ROM memory port between BG0, BG1 and sprite fetches.
// One transaction outstanding; a transaction not acknowledged within TMO
// cycles completes with FILL data and sets the sticky err_tmo flag.
//
// Optional build macro: SEGASYS1_VROM_STARVE_GUARD_EN
//   When defined, a sprite that loses STARVE_LIM consecutive arbitrations
//   while requesting is promoted to win the next one.
//
// Ports:
//   VCLKx8, RESET_N             clock, async active-low reset
//   bg0_req/bg0_ad/bg0_vld      BG0 request, 14-bit address, response strobe
//   bg1_req/bg1_ad/bg1_vld      BG1 request, 14-bit address, response strobe
//   spr_req/spr_ad/spr_vld      sprite request, 18-bit address, strobe
//   rsp_dt                      shared response data (valid with any *_vld)
//   mem_req/mem_sel/mem_ad      memory request, space select, address
//   mem_ack/mem_dt              memory acknowledge with same-cycle data
//   err_clr/err_tmo             sticky timeout flag and its clear
// -----------------------------------------------------------------------------
import segasys1_vid_pkg::*;

module segasys1_vrom_sched #(
    parameter int          TMO        = 48,
    parameter logic [23:0] FILL       = 24'h000000,
    parameter int          STARVE_LIM = 4
) (
    input  logic                VCLKx8,
    input  logic                RESET_N,
    input  logic                bg0_req,
    input  logic [TILE_AW-1:0]  bg0_ad,
    output logic                bg0_vld,
    input  logic                bg1_req,
    input  logic [TILE_AW-1:0]  bg1_ad,
    output logic                bg1_vld,
    input  logic                spr_req,
    input  logic [SPR_AW-1:0]   spr_ad,
    output logic                spr_vld,
    output logic [MEM_DW-1:0]   rsp_dt,
    output logic                mem_req,
    output logic                mem_sel,
    output logic [SPR_AW-1:0]   mem_ad,
    input  logic                mem_ack,
    input  logic [MEM_DW-1:0]   mem_dt,
    input  logic                err_clr,
    output logic                err_tmo
);

    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [1:0]        state_r;
    grant_t            grant_r;
    logic [TW-1:0]     tmo_cnt_r;
    logic [2:0]        vld_r;
    logic [MEM_DW-1:0] rsp_dt_r;
    logic              mem_req_r;
    logic              mem_sel_r;
    logic [SPR_AW-1:0] mem_ad_r;
    logic              err_tmo_r;

    logic              any_req_s;
    grant_t            grant_s;
    logic              promote_s;
    logic              tmo_hit_s;

    segasys1_vrom_prio u_prio (
        .bg0_req (bg0_req),
        .bg1_req (bg1_req),
        .spr_req (spr_req),
        .promote (promote_s),
        .any_req (any_req_s),
        .grant   (grant_s)
    );

    // Last unacknowledged BUSY cycle before the transaction is abandoned.
    assign tmo_hit_s = (state_r == ST_BUSY) && !mem_ack &&
                       (tmo_cnt_r == TW'(TMO - 1));

`ifdef SEGASYS1_VROM_STARVE_GUARD_EN
    logic [2:0] starve_cnt_r;

    assign promote_s = (starve_cnt_r >= 3'(STARVE_LIM));

    // Count consecutive arbitrations lost by a requesting sprite; saturates.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_cnt_r <= 3'd0;
        end else if (!spr_req) begin
            starve_cnt_r <= 3'd0;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            if (grant_s == G_SPR) begin
                starve_cnt_r <= 3'd0;
            end else if (starve_cnt_r < 3'(STARVE_LIM)) begin
                starve_cnt_r <= starve_cnt_r + 3'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    // Pure fixed priority; the limit only matters with the guard built in.
    assign promote_s = (STARVE_LIM < 0);
`endif

    // Scheduler FSM: issue in IDLE, wait for ack or timeout in BUSY, strobe in RESP.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            grant_r   <= G_BG0;
            tmo_cnt_r <= '0;
            vld_r     <= 3'b000;
            rsp_dt_r  <= 24'h000000;
            mem_req_r <= 1'b0;
            mem_sel_r <= MEM_SEL_TILE;
            mem_ad_r  <= 18'h00000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    vld_r <= 3'b000;
                    if (any_req_s) begin
                        grant_r   <= grant_s;
                        mem_req_r <= 1'b1;
                        tmo_cnt_r <= '0;
                        state_r   <= ST_BUSY;
                        case (grant_s)
                            G_BG0: begin
                                mem_sel_r <= MEM_SEL_TILE;
                                mem_ad_r  <= tile_to_mem(bg0_ad);
                            end
                            G_BG1: begin
                                mem_sel_r <= MEM_SEL_TILE;
                                mem_ad_r  <= tile_to_mem(bg1_ad);
                            end
                            G_SPR: begin
                                mem_sel_r <= MEM_SEL_SPR;
                                mem_ad_r  <= spr_ad;
                            end
                            default: begin
                                mem_sel_r <= MEM_SEL_TILE;
                                mem_ad_r  <= tile_to_mem(bg0_ad);
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        rsp_dt_r  <= mem_dt;
                        vld_r     <= grant_onehot(grant_r);
                        mem_req_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end else if (tmo_hit_s) begin
                        rsp_dt_r  <= FILL;
                        vld_r     <= grant_onehot(grant_r);
                        mem_req_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    vld_r   <= 3'b000;
                    state_r <= ST_IDLE;
                end
                default: begin
                    vld_r     <= 3'b000;
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            err_tmo_r <= 1'b0;
        end else if (tmo_hit_s) begin
            err_tmo_r <= 1'b1;
        end else if (err_clr) begin
            err_tmo_r <= 1'b0;
        end else begin
            err_tmo_r <= err_tmo_r;
        end
    end

    assign bg0_vld = vld_r[0];
    assign bg1_vld = vld_r[1];
    assign spr_vld = vld_r[2];
    assign rsp_dt  = rsp_dt_r;
    assign mem_req = mem_req_r;
    assign mem_sel = mem_sel_r;
    assign mem_ad  = mem_ad_r;
    assign err_tmo = err_tmo_r;

endmodule

// File: tb/tb_segasys1_vrom_sched.sv
// -----------------------------------------------------------------------------
// tb_segasys1_vrom_sched
// Self-checking bench for segasys1_vrom_sched. A behavioural memory answers
// requests (or withholds acks); expected responses are queued when stimulus is
// applied and popped when a *_vld strobe appears.
// -----------------------------------------------------------------------------
module tb_segasys1_vrom_sched;

    logic        VCLKx8 = 1'b0;
    logic        RESET_N = 1'b1;
    logic        bg0_req = 1'b0, bg1_req = 1'b0, spr_req = 1'b0;
    logic [13:0] bg0_ad = 14'h0, bg1_ad = 14'h0;
    logic [17:0] spr_ad = 18'h0;
    logic        bg0_vld, bg1_vld, spr_vld;
    logic [23:0] rsp_dt;
    logic        mem_req, mem_sel;
    logic [17:0] mem_ad;
    logic        mem_ack = 1'b0;
    logic [23:0] mem_dt = 24'h0;
    logic        err_clr = 1'b0;
    logic        err_tmo;

    segasys1_vrom_sched dut (
        .VCLKx8  (VCLKx8),
        .RESET_N (RESET_N),
        .bg0_req (bg0_req),
        .bg0_ad  (bg0_ad),
        .bg0_vld (bg0_vld),
        .bg1_req (bg1_req),
        .bg1_ad  (bg1_ad),
        .bg1_vld (bg1_vld),
        .spr_req (spr_req),
        .spr_ad  (spr_ad),
        .spr_vld (spr_vld),
        .rsp_dt  (rsp_dt),
        .mem_req (mem_req),
        .mem_sel (mem_sel),
        .mem_ad  (mem_ad),
        .mem_ack (mem_ack),
        .mem_dt  (mem_dt),
        .err_clr (err_clr),
        .err_tmo (err_tmo)
    );

    always #5 VCLKx8 = ~VCLKx8;

    typedef struct {
        logic [2:0]  vld;
        logic [23:0] dt;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        ack_en = 1'b1;
    logic        dt_ovr_en = 1'b0;
    logic [23:0] dt_ovr = 24'h0;

    logic [2:0]  o_vld;
    logic [23:0] o_dt;
    logic        o_req, o_sel, o_err;
    logic [17:0] o_ad;

    // Memory contents model: data is a fixed scramble of space and address.
    function automatic logic [23:0] mem_fn(input logic sel, input logic [17:0] ad);
        return {ad[5:0], sel, ad[16:0]} ^ 24'h3C3C3C;
    endfunction

    // One clock: sample DUT at negedge, then let the memory react.
    task automatic step();
        @(negedge VCLKx8);
        cyc   = cyc + 1;
        o_vld = {spr_vld, bg1_vld, bg0_vld};
        o_dt  = rsp_dt;
        o_req = mem_req;
        o_sel = mem_sel;
        o_ad  = mem_ad;
        o_err = err_tmo;
        mem_ack = ack_en & mem_req;
        mem_dt  = dt_ovr_en ? dt_ovr : mem_fn(mem_sel, mem_ad);
    endtask

    task automatic test_reset();
        logic [48:0] all_out;
        #1 RESET_N = 1'b0;
        #1;
        all_out = {mem_req, bg0_vld, bg1_vld, spr_vld, err_tmo, mem_sel, mem_ad, rsp_dt};
        n_cmp++;
        if (all_out !== 49'h0) begin
            n_bad++;
            $display("FAIL reset_async outputs got=%h want=0", all_out);
        end
        step();
        step();
        RESET_N = 1'b1;
        step();
        all_out = {o_req, o_vld, o_err, o_sel, o_ad, o_dt};
        n_cmp++;
        if (all_out !== 49'h0) begin
            n_bad++;
            $display("FAIL reset_idle outputs got=%h want=0", all_out);
        end
    endtask

    task automatic test_spr_single();
        rsp_t e;
        ack_en    = 1'b1;
        dt_ovr_en = 1'b1;
        dt_ovr    = 24'hA5A5A5;
        spr_ad    = 18'h1F00F;
        spr_req   = 1'b1;
        rsp_q.push_back('{vld: 3'b100, dt: 24'hA5A5A5});
        step();
        n_cmp++;
        if ({o_req, o_sel, o_ad} !== {1'b1, 1'b1, 18'h1F00F}) begin
            n_bad++;
            $display("FAIL spr_issue got req=%b sel=%b ad=%h want 1 1 1f00f", o_req, o_sel, o_ad);
        end
        step();
        n_cmp++;
        if (o_vld !== 3'b100) begin
            n_bad++;
            $display("FAIL spr_latency vld got=%b want=100", o_vld);
        end
        if (o_vld != 3'b000) begin
            e = rsp_q.pop_front();
            n_cmp++;
            if (o_vld !== e.vld || o_dt !== e.dt) begin
                n_bad++;
                $display("FAIL spr_rsp got vld=%b dt=%h want vld=%b dt=%h", o_vld, o_dt, e.vld, e.dt);
            end
        end
        spr_req = 1'b0;
        step();
        n_cmp++;
        if (o_vld !== 3'b000 || o_dt !== 24'hA5A5A5) begin
            n_bad++;
            $display("FAIL spr_after got vld=%b dt=%h want vld=000 dt=a5a5a5", o_vld, o_dt);
        end
        dt_ovr_en = 1'b0;
    endtask

    task automatic test_all_three();
        rsp_t        e;
        logic        exp_sel [3];
        logic [17:0] exp_ad  [3];
        int          iss = 0, n_rsp = 0, last_rise = 0;
        int          pulses [3];
        logic        prev_req;
        bg0_ad = 14'h1ABC;
        bg1_ad = 14'h0123;
        spr_ad = 18'h2ABCD;
        exp_sel[0] = 1'b0; exp_ad[0] = 18'h01ABC;
        exp_sel[1] = 1'b0; exp_ad[1] = 18'h00123;
        exp_sel[2] = 1'b1; exp_ad[2] = 18'h2ABCD;
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            rsp_q.push_back('{vld: 3'(1 << i), dt: mem_fn(exp_sel[i], exp_ad[i])});
        end
        prev_req = mem_req;
        bg0_req = 1'b1; bg1_req = 1'b1; spr_req = 1'b1;
        for (int c = 0; c < 40 && n_rsp < 3; c++) begin
            step();
            if (o_req && !prev_req) begin
                n_cmp++;
                if (iss > 2) begin
                    n_bad++;
                    $display("FAIL all3_extra_issue count=%0d want<=3", iss + 1);
                end else if (o_sel !== exp_sel[iss] || o_ad !== exp_ad[iss]) begin
                    n_bad++;
                    $display("FAIL all3_issue%0d got sel=%b ad=%h want sel=%b ad=%h",
                             iss, o_sel, o_ad, exp_sel[iss], exp_ad[iss]);
                end
                if (iss > 0) begin
                    n_cmp++;
                    if (cyc - last_rise < 3) begin
                        n_bad++;
                        $display("FAIL all3_spacing got=%0d want>=3", cyc - last_rise);
                    end
                end
                last_rise = cyc;
                iss++;
            end
            prev_req = o_req;
            if (o_vld != 3'b000) begin
                n_rsp++;
                if (o_vld[0]) begin pulses[0]++; bg0_req = 1'b0; end
                if (o_vld[1]) begin pulses[1]++; bg1_req = 1'b0; end
                if (o_vld[2]) begin pulses[2]++; spr_req = 1'b0; end
                n_cmp++;
                if (rsp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL all3_unexpected_vld got=%b want none", o_vld);
                end else begin
                    e = rsp_q.pop_front();
                    if (o_vld !== e.vld || o_dt !== e.dt) begin
                        n_bad++;
                        $display("FAIL all3_rsp got vld=%b dt=%h want vld=%b dt=%h", o_vld, o_dt, e.vld, e.dt);
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (o_vld[0]) pulses[0]++;
            if (o_vld[1]) pulses[1]++;
            if (o_vld[2]) pulses[2]++;
        end
        n_cmp++;
        if (n_rsp != 3 || pulses[0] != 1 || pulses[1] != 1 || pulses[2] != 1 || o_req !== 1'b0) begin
            n_bad++;
            $display("FAIL all3_pulses got rsp=%0d bg0=%0d bg1=%0d spr=%0d req=%b want 3 1 1 1 0",
                     n_rsp, pulses[0], pulses[1], pulses[2], o_req);
        end
    endtask

    task automatic test_timeout();
        rsp_t e;
        int   hi_cnt;
        logic done;
        ack_en = 1'b0;
        bg1_ad = 14'h3FFF;
        for (int pass = 0; pass < 2; pass++) begin
            hi_cnt = 0;
            done   = 1'b0;
            rsp_q.push_back('{vld: 3'b010, dt: 24'h000000});
            bg1_req = 1'b1;
            for (int c = 0; c < 120 && !done; c++) begin
                step();
                if (o_req) hi_cnt++;
                if (o_vld != 3'b000) begin
                    done    = 1'b1;
                    bg1_req = 1'b0;
                    err_clr = 1'b0;
                    e = rsp_q.pop_front();
                    n_cmp++;
                    if (o_vld !== e.vld || o_dt !== e.dt || o_err !== 1'b1 || hi_cnt != 48) begin
                        n_bad++;
                        $display("FAIL tmo_pass%0d got vld=%b dt=%h err=%b req_cycles=%0d want 010 000000 1 48",
                                 pass, o_vld, o_dt, o_err, hi_cnt);
                    end
                end else if (pass == 1 && hi_cnt == 48) begin
                    err_clr = 1'b1;
                end
            end
            n_cmp++;
            if (!done) begin
                n_bad++;
                $display("FAIL tmo_pass%0d_no_vld got none want bg1_vld", pass);
            end
            step();
        end
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_sticky got err=%b want 1", o_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_clear got err=%b want 0", o_err);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_busy();
        rsp_t e;
        ack_en  = 1'b0;
        bg0_ad  = 14'h0555;
        bg0_req = 1'b1;
        step();
        step();
        n_cmp++;
        if (o_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rstbusy_pre got req=%b want 1", o_req);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, bg0_vld, bg1_vld, spr_vld, err_tmo} !== 5'b0) begin
            n_bad++;
            $display("FAIL rstbusy_async got req=%b vld=%b%b%b err=%b want 0",
                     mem_req, spr_vld, bg1_vld, bg0_vld, err_tmo);
        end
        ack_en = 1'b1;
        step();
        RESET_N = 1'b1;
        rsp_q.push_back('{vld: 3'b001, dt: mem_fn(1'b0, 18'h00555)});
        step();
        n_cmp++;
        if ({o_req, o_sel, o_ad} !== {1'b1, 1'b0, 18'h00555}) begin
            n_bad++;
            $display("FAIL rstbusy_reissue got req=%b sel=%b ad=%h want 1 0 00555", o_req, o_sel, o_ad);
        end
        step();
        n_cmp++;
        if (o_vld == 3'b000) begin
            n_bad++;
            $display("FAIL rstbusy_rsp got vld=000 want 001");
        end else begin
            e = rsp_q.pop_front();
            if (o_vld !== e.vld || o_dt !== e.dt) begin
                n_bad++;
                $display("FAIL rstbusy_rsp got vld=%b dt=%h want vld=%b dt=%h", o_vld, o_dt, e.vld, e.dt);
            end
        end
        bg0_req = 1'b0;
        step();
    endtask

    task automatic test_starve();
        rsp_t e;
        logic exp_sel [6];
        int   iss = 0, n_rsp = 0, spr_pulses = 0, exp_spr = 0;
        logic prev_req;
        bg0_ad = 14'h0042;
        spr_ad = 18'h30007;
        for (int i = 0; i < 6; i++) begin
`ifdef SEGASYS1_VROM_STARVE_GUARD_EN
            exp_sel[i] = (i == 4);
`else
            exp_sel[i] = 1'b0;
`endif
            if (exp_sel[i]) exp_spr++;
            rsp_q.push_back(exp_sel[i] ? '{vld: 3'b100, dt: mem_fn(1'b1, 18'h30007)}
                                       : '{vld: 3'b001, dt: mem_fn(1'b0, 18'h00042)});
        end
        prev_req = mem_req;
        bg0_req = 1'b1;
        spr_req = 1'b1;
        for (int c = 0; c < 60 && n_rsp < 6; c++) begin
            step();
            if (o_req && !prev_req && iss < 6) begin
                n_cmp++;
                if (o_sel !== exp_sel[iss]) begin
                    n_bad++;
                    $display("FAIL starve_grant%0d got sel=%b want sel=%b", iss, o_sel, exp_sel[iss]);
                end
                iss++;
            end
            prev_req = o_req;
            if (o_vld != 3'b000) begin
                n_rsp++;
                if (o_vld[2]) spr_pulses++;
                if (n_rsp == 6) begin
                    bg0_req = 1'b0;
                    spr_req = 1'b0;
                end
                n_cmp++;
                if (rsp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL starve_unexpected_vld got=%b want none", o_vld);
                end else begin
                    e = rsp_q.pop_front();
                    if (o_vld !== e.vld || o_dt !== e.dt) begin
                        n_bad++;
                        $display("FAIL starve_rsp got vld=%b dt=%h want vld=%b dt=%h", o_vld, o_dt, e.vld, e.dt);
                    end
                end
            end
        end
        step();
        step();
        n_cmp++;
        if (n_rsp != 6 || spr_pulses != exp_spr || rsp_q.size() != 0) begin
            n_bad++;
            $display("FAIL starve_total got rsp=%0d spr=%0d left=%0d want 6 %0d 0",
                     n_rsp, spr_pulses, rsp_q.size(), exp_spr);
        end
    endtask

    initial begin
        test_reset();
        test_spr_single();
        test_all_three();
        test_timeout();
        test_reset_busy();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
